// File: rtl/fpu_unit.sv
// Multi-cycle IEEE-754 binary32 adder: free-running six-state cycle
// (load, align, add, normalize, round, done) producing one registered result per pass.
module fpu_unit (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic [31:0] op_A_in,
  input  logic [31:0] op_B_in,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic        flags_out
);

  typedef enum logic [2:0] {StLoad, StAlign, StAdd, StNorm, StRound, StDone} state_e;

  localparam logic [3:0] StatusExact    = 4'b0001;
  localparam logic [3:0] StatusOverflow = 4'b0010;
  localparam logic [3:0] StatusUnder    = 4'b0100;
  localparam logic [3:0] StatusInexact  = 4'b1000;

  state_e state_q, state_d;

  logic [31:0]       op_a_q, op_b_q;
  logic              spec_q;
  logic [31:0]       spec_val_q;
  logic              sign_a_q, sign_b_q;
  logic [7:0]        exp_a_q, exp_b_q;
  logic [23:0]       man_a_q, man_b_q;
  logic              sign_l_q, sign_s_q;
  logic [26:0]       man_l_q, man_s_q;
  logic signed [9:0] exp_q;
  logic [27:0]       sum_q;
  logic              sign_q, zero_sign_q;
  logic [26:0]       man_q;
  logic              zero_q;

  // State register and next-state logic
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  state_d = StAlign;
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm:  state_d = StRound;
      StRound: state_d = StDone;
      StDone:  state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  assign flags_out = (state_q == StDone);

  // Load stage: special-operand (exp == 255) resolution
  logic        a_spec, b_spec, a_nan, b_nan;
  logic [31:0] spec_val;

  always_comb begin
    a_spec = &op_a_q[30:23];
    b_spec = &op_b_q[30:23];
    a_nan  = a_spec & (|op_a_q[22:0]);
    b_nan  = b_spec & (|op_b_q[22:0]);
    if (a_nan || b_nan || (a_spec && b_spec && (op_a_q[31] != op_b_q[31]))) begin
      spec_val = 32'h7FC0_0000;
    end else if (a_spec) begin
      spec_val = {op_a_q[31], 8'hFF, 23'd0};
    end else begin
      spec_val = {op_b_q[31], 8'hFF, 23'd0};
    end
  end

  // Align stage: order by magnitude, barrel-shift the smaller with guard/round/sticky
  logic        a_ge, sl, ss;
  logic [7:0]  el, es, diff;
  logic [23:0] ml, ms;
  logic [26:0] ext, shr, lost, shifted;

  always_comb begin
    a_ge = {exp_a_q, man_a_q} >= {exp_b_q, man_b_q};
    sl   = a_ge ? sign_a_q : sign_b_q;
    ss   = a_ge ? sign_b_q : sign_a_q;
    el   = a_ge ? exp_a_q : exp_b_q;
    es   = a_ge ? exp_b_q : exp_a_q;
    ml   = a_ge ? man_a_q : man_b_q;
    ms   = a_ge ? man_b_q : man_a_q;
    diff = el - es;
    ext  = {ms, 3'b000};
    shr  = ext >> diff;
    lost = ext & ~(27'h7FF_FFFF << diff);
    if (diff >= 8'd27) begin
      shifted = {26'd0, |ms};
    end else begin
      shifted = {shr[26:1], shr[0] | (|lost)};
    end
  end

  // Add stage: magnitude add or subtract; larger operand is always on the left
  logic [27:0] sum_d;

  always_comb begin
    if (sign_l_q == sign_s_q) begin
      sum_d = {1'b0, man_l_q} + {1'b0, man_s_q};
    end else begin
      sum_d = {1'b0, man_l_q} - {1'b0, man_s_q};
    end
  end

  // Normalize stage: carry shifts right, otherwise leading-zero left shift
  logic [4:0]        lz;
  logic [26:0]       norm_man;
  logic signed [9:0] norm_exp;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum_q[i]) lz = 5'(26 - i);
    end
    if (sum_q[27]) begin
      norm_man = {sum_q[27:2], sum_q[1] | sum_q[0]};
      norm_exp = exp_q + 10'sd1;
    end else begin
      norm_man = sum_q[26:0] << lz;
      norm_exp = exp_q - $signed({5'd0, lz});
    end
  end

  // Round stage: nearest-even on G/R/S, then classify the result
  logic              g_bit, r_bit, s_bit, rnd_up;
  logic [24:0]       rnd;
  logic [22:0]       frac;
  logic signed [9:0] fexp;
  logic [31:0]       result;
  logic [3:0]        status;

  always_comb begin
    g_bit  = man_q[2];
    r_bit  = man_q[1];
    s_bit  = man_q[0];
    rnd_up = g_bit & (r_bit | s_bit | man_q[3]);
    rnd    = {1'b0, man_q[26:3]} + {24'd0, rnd_up};
    if (rnd[24]) begin
      frac = rnd[23:1];
      fexp = exp_q + 10'sd1;
    end else begin
      frac = rnd[22:0];
      fexp = exp_q;
    end
    result = {sign_q, fexp[7:0], frac};
    status = StatusExact;
    if (spec_q) begin
      result = spec_val_q;
      status = StatusOverflow;
    end else if (zero_q) begin
      result = {zero_sign_q, 31'd0};
      status = StatusExact;
    end else if (exp_q <= 10'sd0) begin
      result = {sign_q, 31'd0};
      status = StatusUnder;
    end else if (fexp >= 10'sd255) begin
      result = {sign_q, 8'hFF, 23'd0};
      status = StatusOverflow;
    end else if (g_bit || r_bit || s_bit) begin
      status = StatusInexact;
    end
  end

  // Datapath registers; operands are sampled on the edge entering LOAD
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      spec_q      <= 1'b0;
      spec_val_q  <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      man_a_q     <= '0;
      man_b_q     <= '0;
      sign_l_q    <= 1'b0;
      sign_s_q    <= 1'b0;
      man_l_q     <= '0;
      man_s_q     <= '0;
      exp_q       <= '0;
      sum_q       <= '0;
      sign_q      <= 1'b0;
      zero_sign_q <= 1'b0;
      man_q       <= '0;
      zero_q      <= 1'b0;
      data_out    <= '0;
      status_out  <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          sign_a_q   <= op_a_q[31];
          sign_b_q   <= op_b_q[31];
          exp_a_q    <= op_a_q[30:23];
          exp_b_q    <= op_b_q[30:23];
          // Denormal inputs flush to zero
          man_a_q    <= (op_a_q[30:23] == 8'd0) ? 24'd0 : {1'b1, op_a_q[22:0]};
          man_b_q    <= (op_b_q[30:23] == 8'd0) ? 24'd0 : {1'b1, op_b_q[22:0]};
          spec_q     <= a_spec | b_spec;
          spec_val_q <= spec_val;
        end
        StAlign: begin
          sign_l_q <= sl;
          sign_s_q <= ss;
          exp_q    <= $signed({2'b00, el});
          man_l_q  <= {ml, 3'b000};
          man_s_q  <= shifted;
        end
        StAdd: begin
          sum_q       <= sum_d;
          sign_q      <= sign_l_q;
          zero_sign_q <= sign_l_q & sign_s_q;
        end
        StNorm: begin
          man_q  <= norm_man;
          exp_q  <= norm_exp;
          zero_q <= (sum_q == 28'd0);
        end
        StRound: begin
          data_out   <= result;
          status_out <= status;
        end
        StDone: begin
          op_a_q <= op_A_in;
          op_b_q <= op_B_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_unit.sv
// Self-checking bench for fpu_unit: directed cases plus randomized operands checked
// against an exact wide-integer reference adder.
`timescale 1ns/1ps
module tb_fpu_unit;

  logic        clock100KHz = 1'b0;
  logic        reset       = 1'b0;
  logic [31:0] op_A_in     = '0;
  logic [31:0] op_B_in     = '0;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        flags_out;

  int          checks    = 0;
  int          failures  = 0;
  logic [31:0] prev_data = '0;

  fpu_unit dut (
    .clock100KHz(clock100KHz),
    .reset      (reset),
    .op_A_in    (op_A_in),
    .op_B_in    (op_B_in),
    .data_out   (data_out),
    .status_out (status_out),
    .flags_out  (flags_out)
  );

  always #5000 clock100KHz = ~clock100KHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Exact sum as a scaled integer (unit 2^-149), then round-nearest-even to 24 bits.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] st);
    logic [299:0] xa, xb, x, rem, half;
    logic [24:0]  mant;
    logic [7:0]   ea, eb;
    logic [22:0]  fa, fb;
    logic         sa, sb, s;
    int           p, e, sh;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    r  = '0;
    st = 4'b0001;
    if (ea == 8'hFF || eb == 8'hFF) begin
      st = 4'b0010;
      if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
          (ea == 8'hFF && eb == 8'hFF && sa != sb)) r = 32'h7FC0_0000;
      else if (ea == 8'hFF) r = {sa, 8'hFF, 23'd0};
      else r = {sb, 8'hFF, 23'd0};
    end else begin
      xa = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 8'd1));
      xb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 8'd1));
      if (sa == sb) begin
        x = xa + xb; s = sa;
      end else if (xa >= xb) begin
        x = xa - xb; s = sa;
      end else begin
        x = xb - xa; s = sb;
      end
      if (x == 0) begin
        r  = {sa & sb, 31'd0};
        st = 4'b0001;
      end else begin
        p = 0;
        for (int i = 0; i < 300; i++) if (x[i]) p = i;
        e = p - 22;
        if (e <= 0) begin
          r  = {s, 31'd0};
          st = 4'b0100;
        end else begin
          sh   = p - 23;
          mant = 25'(x >> sh);
          rem  = x & ((300'd1 << sh) - 300'd1);
          half = (sh > 0) ? (300'd1 << (sh - 1)) : '0;
          if (sh > 0 && (rem > half || (rem == half && mant[0]))) mant = mant + 25'd1;
          if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
          end
          if (e >= 255) begin
            r  = {s, 8'hFF, 23'd0};
            st = 4'b0010;
          end else begin
            r  = {s, 8'(e), mant[22:0]};
            st = (rem != 0) ? 4'b1000 : 4'b0001;
          end
        end
      end
    end
  endfunction

  // Entered while the DUT is in DONE; returns in DONE of the next result.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic [3:0]  es;
    int          k;
    ref_add(a, b, er, es);
    op_A_in = a;
    op_B_in = b;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock100KHz);
      if (i == 3) check({tag, " hold"}, data_out, prev_data);
      if (flags_out) begin
        k = i;
        break;
      end
    end
    check({tag, " latency"}, 32'(k), 32'd6);
    check({tag, " data"}, data_out, er);
    check({tag, " status"}, {28'd0, status_out}, {28'd0, es});
    prev_data = er;
  endtask

  initial begin
    int          k;
    int          ea_i, eb_i, sel;
    logic [31:0] ra, rb;

    #1;
    check("rst data", data_out, 32'd0);
    check("rst status", {28'd0, status_out}, 32'd0);
    check("rst flags", {31'd0, flags_out}, 32'd0);
    #9 reset = 1'b1;

    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock100KHz);
      if (flags_out) begin
        k = i;
        break;
      end
    end
    check("first pulse edges", 32'(k), 32'd5);
    check("first data", data_out, 32'd0);
    check("first status", {28'd0, status_out}, 32'd1);
    @(negedge clock100KHz);
    check("pulse width", {31'd0, flags_out}, 32'd0);
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock100KHz);
      if (flags_out) begin
        k = i;
        break;
      end
    end
    check("pulse period", 32'(k), 32'd5);

    run_op("1+1", 32'h3F80_0000, 32'h3F80_0000);
    run_op("3-1", 32'h4040_0000, 32'hBF80_0000);
    run_op("cancel", 32'h3FC0_0000, 32'hBFC0_0000);
    run_op("neg zeros", 32'h8000_0000, 32'h8000_0000);
    run_op("tie even", 32'h3F80_0000, 32'h3380_0000);
    run_op("round up", 32'h3F80_0000, 32'h33C0_0000);
    run_op("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF);
    run_op("inf-inf", 32'h7F80_0000, 32'hFF80_0000);
    run_op("inf+1", 32'hFF80_0000, 32'h3F80_0000);
    run_op("underflow", 32'h0080_0001, 32'h8080_0000);

    // Abort an operation in ALIGN: outputs clear at once, no pulse for it
    op_A_in = 32'h3F80_0000;
    op_B_in = 32'h3F80_0000;
    @(negedge clock100KHz);
    @(negedge clock100KHz);
    reset   = 1'b0;
    op_A_in = '0;
    op_B_in = '0;
    #1;
    check("abort data", data_out, 32'd0);
    check("abort status", {28'd0, status_out}, 32'd0);
    check("abort flags", {31'd0, flags_out}, 32'd0);
    @(negedge clock100KHz);
    check("abort hold flags", {31'd0, flags_out}, 32'd0);
    @(negedge clock100KHz);
    reset = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock100KHz);
      if (flags_out) begin
        k = i;
        break;
      end
      check("abort no result", data_out, 32'd0);
    end
    check("restart edges", 32'(k), 32'd5);
    check("restart data", data_out, 32'd0);
    prev_data = 32'd0;

    for (int n = 0; n < 150; n++) begin
      ea_i = int'($urandom_range(1, 254));
      eb_i = ea_i + int'($urandom_range(0, 60)) - 30;
      if (eb_i < 1) eb_i = 1;
      if (eb_i > 254) eb_i = 254;
      ra  = {1'($urandom_range(0, 1)), 8'(ea_i), 23'($urandom)};
      rb  = {1'($urandom_range(0, 1)), 8'(eb_i), 23'($urandom)};
      sel = int'($urandom_range(0, 15));
      case (sel)
        0: rb = {~ra[31], ra[30:0]};
        1: rb = {1'($urandom_range(0, 1)), 31'd0};
        2: rb = {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
        3: ra = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
        4: rb = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
        5: begin
          ra[12:0] = '0;
          rb[12:0] = '0;
        end
        6: begin
          ra = {1'b0, 8'd254, 23'($urandom)};
          rb = {1'b0, 8'(253 + $urandom_range(0, 1)), 23'($urandom)};
        end
        7: begin
          ra = {1'b0, 8'd1, 23'($urandom)};
          rb = {1'b1, 8'(1 + $urandom_range(0, 1)), 23'($urandom)};
        end
        default: ;
      endcase
      run_op("random", ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
